// File: rtl/rd_stage_sequencer_pkg.sv
// Shared definitions for the rd_stage schedule: FSM encoding, stage limits and
// the CE-mode stage mask also used by the compute-engine control decoders.
package rd_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int          DEF_NUM_STAGES = 12;
  localparam logic [3:0]  STAGE_LAST     = 4'(DEF_NUM_STAGES - 1);

  // Bit n set means stage n is a CE-mode stage (6, 7, 9, 10).
  localparam logic [15:0] CE_STAGE_MASK  = 16'h06C0;

endpackage

// File: rtl/rd_stage_next.sv
// Combinational next-stage function: stage+1, hopping over CE-mode stages
// when skip_ce is set.
module rd_stage_next
  import rd_stage_sequencer_pkg::*;
(
  input  logic       skip_ce,
  input  logic [3:0] stage,
  output logic [3:0] next_stage
);

  logic       found;
  logic [3:0] cand;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_stage = stage + 4'd1;
    found      = 1'b0;
    cand       = 4'd0;
    for (int i = 1; i < 16; i++) begin
      cand = stage + 4'(i);
      if (!found && !(skip_ce && CE_STAGE_MASK[cand])) begin
        next_stage = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_stage_sequencer.sv
// Steps rd_stage 0..NUM_STAGES-1 with a programmable beat count per stage,
// handshaken on rd_valid/rd_ready. Optional CE-stage skipping: RD_STAGE_SKIP_EN.
module rd_stage_sequencer
  import rd_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int BEAT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RD_STAGE_SKIP_EN
  input  logic              ce_enable,
`endif
  input  logic              start,
  input  logic              abort,
  input  logic [BEAT_W-1:0] beats_per_stage,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [3:0]        rd_stage,
  output logic [BEAT_W-1:0] rd_beat,
  output logic              stage_last,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_STAGES - 1);

  seq_state_t        state, state_next;
  logic [BEAT_W-1:0] len_q;
  logic [BEAT_W-1:0] beat_q;
  logic [3:0]        stage_q;
  logic [3:0]        stage_nxt;
  logic              skip_q;
  logic              consume;
  logic              beat_last;
  logic              final_beat;

  assign consume    = (state == ST_RUN) && rd_ready;
  assign beat_last  = (beat_q == len_q - BEAT_W'(1));
  assign final_beat = consume && beat_last && (stage_q == LAST_IDX);

  rd_stage_next u_next (
    .skip_ce    (skip_q),
    .stage      (stage_q),
    .next_stage (stage_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        rd_valid = 1'b1;
        busy     = 1'b1;
        // Abort takes priority over a simultaneous final consume.
        if (abort)           state_next = ST_IDLE;
        else if (final_beat) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= BEAT_W'(1);
      beat_q  <= '0;
      stage_q <= '0;
      skip_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          len_q   <= (beats_per_stage == '0) ? BEAT_W'(1) : beats_per_stage;
          beat_q  <= '0;
          stage_q <= '0;
`ifdef RD_STAGE_SKIP_EN
          skip_q  <= ~ce_enable;
`else
          skip_q  <= 1'b0;
`endif
        end
        ST_RUN: begin
          if (abort || final_beat) begin
            beat_q  <= '0;
            stage_q <= '0;
          end else if (consume) begin
            if (beat_last) begin
              beat_q  <= '0;
              stage_q <= stage_nxt;
            end else begin
              beat_q  <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: begin
          beat_q  <= '0;
          stage_q <= '0;
        end
      endcase
    end
  end

  assign rd_stage   = stage_q;
  assign rd_beat    = beat_q;
  assign stage_last = rd_valid && beat_last;

endmodule

// File: tb/tb_rd_stage_sequencer.sv
// Directed self-checking bench for rd_stage_sequencer: a vector table plus
// hand-written multi-cycle sequences (full runs, stalls, abort, reset, skip).
module tb_rd_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce_enable;
  logic       start;
  logic       abort;
  logic [7:0] beats_per_stage;
  logic       rd_ready;
  logic       rd_valid;
  logic [3:0] rd_stage;
  logic [7:0] rd_beat;
  logic       stage_last;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rd_stage_sequencer #(.NUM_STAGES(12), .BEAT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef RD_STAGE_SKIP_EN
    .ce_enable       (ce_enable),
`endif
    .start           (start),
    .abort           (abort),
    .beats_per_stage (beats_per_stage),
    .rd_ready        (rd_ready),
    .rd_valid        (rd_valid),
    .rd_stage        (rd_stage),
    .rd_beat         (rd_beat),
    .stage_last      (stage_last),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic       start;
    logic       abort;
    logic       rdy;
    logic [7:0] bps;
    logic       valid;
    logic [3:0] stage;
    logic [7:0] beat;
    logic       last;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic s, a, r, input logic [7:0] b,
                              input logic v, input logic [3:0] st,
                              input logic [7:0] bt, input logic l, bs, d);
    vec_t x;
    x.start = s; x.abort = a; x.rdy = r; x.bps = b;
    x.valid = v; x.stage = st; x.beat = bt; x.last = l; x.busy = bs; x.done = d;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packed {valid, stage, beat, last, busy, done}.
  task automatic check_out(input string name, input logic v, input int st, input int bt,
                           input logic l, input logic bs, input logic d);
    logic [15:0] act, exp;
    act = {rd_valid, rd_stage, rd_beat, stage_last, busy, done};
    exp = {v, 4'(st), 8'(bt), l, bs, d};
    check(name, 32'(act), 32'(exp));
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: rd_ready always 1; mode 1: rd_ready pattern 1,0,0,1,0,0,...
  task automatic run_sched(input logic [7:0] bps, input int mode, input bit skip,
                           input string tag);
    int leff, k, consumes, cyc;
    bit rdy, taken;
    int stages[$];
    leff = (bps == 8'd0) ? 1 : int'(bps);
    if (skip) stages = '{0, 1, 2, 3, 4, 5, 8, 11};
    else for (int s = 0; s < 12; s++) stages.push_back(s);
    start = 1'b1; beats_per_stage = bps; rd_ready = 1'b0;
    tick();
    start = 1'b0;
    beats_per_stage = 8'd7;  // must be ignored mid-run
    k = 0; consumes = 0; cyc = 0;
    foreach (stages[si]) begin
      for (int b = 0; b < leff; b++) begin
        taken = 1'b0;
        while (!taken && cyc < 2000) begin
          rdy = (mode == 0) ? 1'b1 : ((k % 3) == 0);
          k++;
          check_out({tag, "_run"}, 1'b1, stages[si], b, (b == leff - 1), 1'b1, 1'b0);
          rd_ready = rdy;
          tick();
          cyc++;
          if (rdy) begin
            taken = 1'b1;
            consumes++;
          end
        end
      end
    end
    rd_ready = 1'b0;
    check({tag, "_consumes"}, 32'(consumes), 32'(stages.size() * leff));
    check({tag, "_valid_cycles"}, 32'(cyc),
          32'((mode == 0) ? stages.size() * leff : 3 * stages.size() * leff - 2));
    check_out({tag, "_done"}, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    check_out({tag, "_idle"}, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ce_enable = 1'b1; start = 1'b1; abort = 1'b1;
    beats_per_stage = 8'd2; rd_ready = 1'b1;
    @(negedge clk);
    tick();
    check_out("reset_state", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    rst = 1'b0;
    tick();
    check_out("post_reset_idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Full schedules: 2 beats/stage, 0 (treated as 1), and 3 with stalls.
    run_sched(8'd2, 0, 1'b0, "bps2");
    run_sched(8'd0, 0, 1'b0, "bps0");
    run_sched(8'd3, 1, 1'b0, "bps3_stall");

    // Table: L=1 run with start re-pulsed in RUN and DONE, one stall, idle abort.
    tbl[0] = mk(1, 0, 1, 8'd1, 1, 4'd0, 8'd0, 1, 1, 0);
    tbl[1] = mk(1, 0, 1, 8'd5, 1, 4'd1, 8'd0, 1, 1, 0);
    tbl[2] = mk(0, 0, 0, 8'd5, 1, 4'd1, 8'd0, 1, 1, 0);
    for (int i = 3; i <= 12; i++) tbl[i] = mk(0, 0, 1, 8'd5, 1, 4'(i - 1), 8'd0, 1, 1, 0);
    tbl[13] = mk(0, 0, 1, 8'd5, 0, 4'd0, 8'd0, 0, 0, 1);
    tbl[14] = mk(1, 0, 0, 8'd5, 0, 4'd0, 8'd0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 8'd5, 0, 4'd0, 8'd0, 0, 0, 0);
    tbl[16] = mk(0, 1, 1, 8'd5, 0, 4'd0, 8'd0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; abort = tbl[i].abort;
      rd_ready = tbl[i].rdy; beats_per_stage = tbl[i].bps;
      tick();
      check_out($sformatf("tbl_%0d", i), tbl[i].valid, int'(tbl[i].stage),
                int'(tbl[i].beat), tbl[i].last, tbl[i].busy, tbl[i].done);
    end
    start = 1'b0; abort = 1'b0; rd_ready = 1'b0;

    // Abort at stage 5 beat 1 (L=2): 11 consumes reach it.
    start = 1'b1; beats_per_stage = 8'd2; tick(); start = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check_out("abort_pre", 1'b1, 5, 1, 1'b1, 1'b1, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0; rd_ready = 1'b0;
    check_out("abort_idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("abort_no_done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    start = 1'b1; beats_per_stage = 8'd2; tick(); start = 1'b0;
    check_out("restart_s0", 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    rd_ready = 1'b1; tick();
    check_out("restart_b1", 1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0; rd_ready = 1'b0;

    // Abort wins over the final consume of stage 11.
    start = 1'b1; beats_per_stage = 8'd1; tick(); start = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check_out("final_pre", 1'b1, 11, 0, 1'b1, 1'b1, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0; rd_ready = 1'b0;
    check_out("abort_vs_final", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("abort_vs_final_nodone", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // rst at stage 7 (L=2: 14 consumes) clears everything, also beats a start.
    start = 1'b1; beats_per_stage = 8'd2; tick(); start = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check_out("rst_pre", 1'b1, 7, 0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; start = 1'b1; tick();
    check_out("rst_mid_run", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0; rd_ready = 1'b0;
    tick();
    check_out("rst_released", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef RD_STAGE_SKIP_EN
    ce_enable = 1'b0;
    run_sched(8'd1, 0, 1'b1, "skip_ce");
    ce_enable = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
